// File: rtl/sync_fifo_ctrl.sv
// Pointer/flag controller for a synchronous FIFO driving a dual-port memory.
// Optional almost_full/almost_empty flags are enabled by defining SYNC_FIFO_ALMOST_EN.
module sync_fifo_ctrl #(
  parameter int W = 8,
  parameter int L = 5
`ifdef SYNC_FIFO_ALMOST_EN
  ,
  parameter int AF_TH = 28,
  parameter int AE_TH = 4
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [L:0]   count,
  output logic         dout_valid,
  output logic         overflow,
  output logic         underflow,
`ifdef SYNC_FIFO_ALMOST_EN
  output logic         almost_full,
  output logic         almost_empty,
`endif
  output logic [W-1:0] mem_data_a,
  output logic [L-1:0] mem_addr_a,
  output logic         mem_wr_n,
  output logic [L-1:0] mem_addr_b,
  output logic         mem_rd_n
);

  localparam logic [L:0] DEPTH = {1'b1, {L{1'b0}}};

  logic [L:0] r_wptr;
  logic [L:0] r_rptr;
  logic [L:0] r_count;
  logic       r_full;
  logic       r_empty;
  logic       r_dv;
  logic       r_ovf;
  logic       r_unf;

  logic       w_push_ok;
  logic       w_pop_ok;
  logic [L:0] w_wptr_nxt;
  logic [L:0] w_rptr_nxt;
  logic [L:0] w_cnt_nxt;

  // Requests are judged against the flags registered at the start of the cycle.
  assign w_push_ok = push & ~r_full & ~rst;
  assign w_pop_ok  = pop & ~r_empty & ~rst;

  // Wrap bits make the pointer difference the true occupancy, 0..2^L.
  assign w_wptr_nxt = r_wptr + {{L{1'b0}}, w_push_ok};
  assign w_rptr_nxt = r_rptr + {{L{1'b0}}, w_pop_ok};
  assign w_cnt_nxt  = w_wptr_nxt - w_rptr_nxt;

  assign mem_data_a = din;
  assign mem_addr_a = r_wptr[L-1:0];
  assign mem_wr_n   = ~w_push_ok;
  assign mem_addr_b = r_rptr[L-1:0];
  assign mem_rd_n   = ~w_pop_ok;

  assign full       = r_full;
  assign empty      = r_empty;
  assign count      = r_count;
  assign dout_valid = r_dv;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_dv    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == DEPTH);
      r_empty <= (w_cnt_nxt == '0);
      r_dv    <= w_pop_ok;
      if (push & r_full)
        r_ovf <= 1'b1;
      if (pop & r_empty)
        r_unf <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_ALMOST_EN
  localparam logic [L:0] AF_LIM = AF_TH[L:0];
  localparam logic [L:0] AE_LIM = AE_TH[L:0];

  logic r_afull;
  logic r_aempty;

  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_afull  <= (w_cnt_nxt >= AF_LIM);
      r_aempty <= (w_cnt_nxt <= AE_LIM);
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl with a queue-based reference model and a memory model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, dout_valid, overflow, underflow;
  logic [5:0] count;
  logic [7:0] mem_data_a;
  logic [4:0] mem_addr_a, mem_addr_b;
  logic       mem_wr_n, mem_rd_n;
`ifdef SYNC_FIFO_ALMOST_EN
  logic       almost_full, almost_empty;
`endif

  sync_fifo_ctrl dut (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .full(full), .empty(empty), .count(count), .dout_valid(dout_valid),
    .overflow(overflow), .underflow(underflow),
`ifdef SYNC_FIFO_ALMOST_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .mem_data_a(mem_data_a), .mem_addr_a(mem_addr_a), .mem_wr_n(mem_wr_n),
    .mem_addr_b(mem_addr_b), .mem_rd_n(mem_rd_n)
  );

  always #5 clk = ~clk;

  // Dual-port memory with synchronous read, as seen by the controller.
  logic [7:0] mem [32];
  logic [7:0] data_b = 8'h00;
  always @(posedge clk) begin
    if (!mem_wr_n) mem[mem_addr_a] <= mem_data_a;
    if (!mem_rd_n) data_b <= mem[mem_addr_b];
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf, m_unf, m_dv;
  logic [7:0] m_dout;
  int         m_wa, m_ra;

  // Pre-edge expected and captured strobe values
  bit         e_wr_n, e_rd_n;
  logic [4:0] e_aa, e_ab;
  logic       a_wr_n, a_rd_n;
  logic [4:0] a_aa, a_ab;
  logic [7:0] a_dat;

  task automatic cyc(input bit p, input bit o, input logic [7:0] d, input bit r);
    bit pok, ook;
    @(negedge clk);
    push = p; pop = o; din = d; rst = r;
    #1;
    pok = p && (q.size() < 32) && !r;
    ook = o && (q.size() > 0) && !r;
    e_wr_n = !pok; e_rd_n = !ook;
    e_aa = m_wa[4:0]; e_ab = m_ra[4:0];
    a_wr_n = mem_wr_n; a_rd_n = mem_rd_n;
    a_aa = mem_addr_a; a_ab = mem_addr_b; a_dat = mem_data_a;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_dv = 0; m_wa = 0; m_ra = 0;
    end else begin
      if (p && q.size() == 32) m_ovf = 1;
      if (o && q.size() == 0) m_unf = 1;
      m_dv = ook;
      if (ook) begin m_dout = q.pop_front(); m_ra++; end
      if (pok) begin q.push_back(d); m_wa++; end
    end
    #1;
  endtask

  task automatic test_reset();
    cyc(1, 1, 8'h55, 1);
    n_cmp++; if (a_wr_n !== 1'b1) begin n_bad++; $display("FAIL rst_wr_n: got %b want 1", a_wr_n); end
    n_cmp++; if (a_rd_n !== 1'b1) begin n_bad++; $display("FAIL rst_rd_n: got %b want 1", a_rd_n); end
    cyc(0, 0, 8'h00, 1);
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", full); end
    n_cmp++; if (count !== 6'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", count); end
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL rst_dv: got %b want 0", dout_valid); end
    n_cmp++; if ({overflow, underflow} !== 2'b00) begin n_bad++; $display("FAIL rst_err: got %b%b want 00", overflow, underflow); end
`ifdef SYNC_FIFO_ALMOST_EN
    n_cmp++; if ({almost_full, almost_empty} !== 2'b01) begin n_bad++; $display("FAIL rst_almost: got %b%b want 01", almost_full, almost_empty); end
`endif
  endtask

  task automatic test_fill_drain();
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 8'(i), 0);
      n_cmp++; if (a_wr_n !== 1'b0 || a_aa !== e_aa || a_dat !== 8'(i)) begin
        n_bad++; $display("FAIL fill_wr[%0d]: got wr_n=%b addr=%0d data=%h want 0/%0d/%h", i, a_wr_n, a_aa, a_dat, e_aa, 8'(i));
      end
    end
    n_cmp++; if (full !== 1'b1 || count !== 6'd32 || empty !== 1'b0) begin
      n_bad++; $display("FAIL fill_full: got full=%b count=%0d empty=%b want 1/32/0", full, count, empty);
    end
    cyc(1, 0, 8'hEE, 0);
    n_cmp++; if (a_wr_n !== 1'b1) begin n_bad++; $display("FAIL ovf_wr_n: got %b want 1", a_wr_n); end
    n_cmp++; if (overflow !== 1'b1 || count !== 6'd32) begin
      n_bad++; $display("FAIL ovf_flag: got ovf=%b count=%0d want 1/32", overflow, count);
    end
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 8'h00, 0);
      n_cmp++; if (a_rd_n !== 1'b0 || a_ab !== e_ab) begin
        n_bad++; $display("FAIL drain_rd[%0d]: got rd_n=%b addr=%0d want 0/%0d", i, a_rd_n, a_ab, e_ab);
      end
      n_cmp++; if (dout_valid !== 1'b1 || data_b !== 8'(i) || data_b !== m_dout) begin
        n_bad++; $display("FAIL drain_data[%0d]: got dv=%b data=%h want 1/%h", i, dout_valid, data_b, 8'(i));
      end
    end
    n_cmp++; if (empty !== 1'b1 || count !== 6'd0 || underflow !== 1'b0) begin
      n_bad++; $display("FAIL drain_empty: got empty=%b count=%0d unf=%b want 1/0/0", empty, count, underflow);
    end
    cyc(0, 0, 8'h00, 0);
    n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL drain_dv_idle: got %b want 0", dout_valid); end
  endtask

  task automatic test_single();
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'hA5, 0);
    n_cmp++; if (empty !== 1'b0 || count !== 6'd1) begin
      n_bad++; $display("FAIL single_push: got empty=%b count=%0d want 0/1", empty, count);
    end
    cyc(0, 1, 8'h00, 0);
    n_cmp++; if (a_rd_n !== 1'b0) begin n_bad++; $display("FAIL single_rd_n: got %b want 0", a_rd_n); end
    n_cmp++; if (dout_valid !== 1'b1 || data_b !== 8'hA5 || count !== 6'd0) begin
      n_bad++; $display("FAIL single_data: got dv=%b data=%h count=%0d want 1/a5/0", dout_valid, data_b, count);
    end
  endtask

  task automatic test_boundaries();
    cyc(0, 0, 8'h00, 1);
    cyc(1, 1, 8'h3C, 0);
    n_cmp++; if (a_wr_n !== 1'b0 || a_rd_n !== 1'b1) begin
      n_bad++; $display("FAIL empty_pp_strobes: got wr_n=%b rd_n=%b want 0/1", a_wr_n, a_rd_n);
    end
    n_cmp++; if (underflow !== 1'b1 || count !== 6'd1 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL empty_pp_state: got unf=%b count=%0d dv=%b want 1/1/0", underflow, count, dout_valid);
    end
    for (int i = 0; i < 31; i++) cyc(1, 0, 8'($urandom), 0);
    n_cmp++; if (full !== 1'b1 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL full_reach: got full=%b ovf=%b want 1/0", full, overflow);
    end
    cyc(1, 1, 8'h99, 0);
    n_cmp++; if (a_wr_n !== 1'b1 || a_rd_n !== 1'b0) begin
      n_bad++; $display("FAIL full_pp_strobes: got wr_n=%b rd_n=%b want 1/0", a_wr_n, a_rd_n);
    end
    n_cmp++; if (overflow !== 1'b1 || count !== 6'd31 || full !== 1'b0) begin
      n_bad++; $display("FAIL full_pp_state: got ovf=%b count=%0d full=%b want 1/31/0", overflow, count, full);
    end
    n_cmp++; if (dout_valid !== 1'b1 || data_b !== 8'h3C) begin
      n_bad++; $display("FAIL full_pp_data: got dv=%b data=%h want 1/3c", dout_valid, data_b);
    end
  endtask

  task automatic test_wrap();
    bit p, o;
    cyc(0, 0, 8'h00, 1);
    cyc(1, 0, 8'($urandom), 0);
    for (int i = 0; i < 150; i++) begin
      p = (q.size() < 3) && ($urandom_range(0, 3) != 0);
      o = (q.size() >= 2 || (q.size() == 1 && p)) && ($urandom_range(0, 1) == 1);
      cyc(p, o, 8'($urandom), 0);
      n_cmp++; if (a_wr_n !== e_wr_n || a_rd_n !== e_rd_n || a_aa !== e_aa || a_ab !== e_ab) begin
        n_bad++; $display("FAIL wrap_strobe[%0d]: got %b %b %0d %0d want %b %b %0d %0d",
          i, a_wr_n, a_rd_n, a_aa, a_ab, e_wr_n, e_rd_n, e_aa, e_ab);
      end
      n_cmp++; if (count !== 6'(q.size()) || dout_valid !== m_dv) begin
        n_bad++; $display("FAIL wrap_state[%0d]: got count=%0d dv=%b want %0d/%b", i, count, dout_valid, q.size(), m_dv);
      end
      if (m_dv) begin
        n_cmp++; if (data_b !== m_dout) begin
          n_bad++; $display("FAIL wrap_data[%0d]: got %h want %h", i, data_b, m_dout);
        end
      end
    end
    n_cmp++; if (m_wa < 33) begin n_bad++; $display("FAIL wrap_reach: got %0d writes want >=33", m_wa); end
  endtask

  task automatic test_reset_mid();
    cyc(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'($urandom), 0);
    n_cmp++; if (count !== 6'd10) begin n_bad++; $display("FAIL mid_pre: got %0d want 10", count); end
    cyc(1, 1, 8'h77, 1);
    n_cmp++; if (a_wr_n !== 1'b1 || a_rd_n !== 1'b1) begin
      n_bad++; $display("FAIL mid_strobes: got wr_n=%b rd_n=%b want 1/1", a_wr_n, a_rd_n);
    end
    n_cmp++; if (empty !== 1'b1 || count !== 6'd0 || dout_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_empty: got empty=%b count=%0d dv=%b want 1/0/0", empty, count, dout_valid);
    end
    cyc(0, 1, 8'h00, 0);
    n_cmp++; if (a_rd_n !== 1'b1 || underflow !== 1'b1) begin
      n_bad++; $display("FAIL mid_pop_empty: got rd_n=%b unf=%b want 1/1", a_rd_n, underflow);
    end
  endtask

`ifdef SYNC_FIFO_ALMOST_EN
  task automatic test_almost();
    cyc(0, 0, 8'h00, 1);
    for (int i = 1; i <= 28; i++) begin
      cyc(1, 0, 8'($urandom), 0);
      n_cmp++; if (almost_full !== (i >= 28) || almost_empty !== (i <= 4)) begin
        n_bad++; $display("FAIL almost[%0d]: got af=%b ae=%b want %b/%b", i, almost_full, almost_empty, i >= 28, i <= 4);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_single();
    test_boundaries();
    test_wrap();
    test_reset_mid();
`ifdef SYNC_FIFO_ALMOST_EN
    test_almost();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
